// File: rtl/operand_loader.sv
// operand_loader: debounces load/shift buttons, captures two operands, issues WIDTH shift steps
module operand_loader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_btn,
    input  logic                       shift_btn,
    input  logic [WIDTH-1:0]           sw,
    output logic [WIDTH-1:0]           op_a,
    output logic [WIDTH-1:0]           op_b,
    output logic                       operands_valid,
    output logic                       step,
    output logic [$clog2(WIDTH+1)-1:0] step_count,
    output logic                       done
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, HAVE_A, READY, SHIFTING, DONE} state_t;

    // Bit 0 is the load button, bit 1 the shift button.
    logic [1:0]    sync1_q, sync2_q, stable_q, prev_q, pulse_q;
    logic [CW-1:0] cnt_q [2];
    logic          load_p, shift_p;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [SW-1:0]    step_count_q;
    logic             step_q;

    assign load_p  = pulse_q[0];
    assign shift_p = pulse_q[1];

    // Synchronize, debounce and edge-detect both buttons in parallel.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= {shift_btn, load_btn};
            sync2_q <= sync1_q;
            prev_q  <= stable_q;
            pulse_q <= stable_q & ~prev_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q[i]    <= '0;
                    stable_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Operand capture and shift sequencing; each state accepts at most one event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            step_count_q <= '0;
            step_q       <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                IDLE: if (load_p) begin
                    op_a_q  <= sw;
                    state_q <= HAVE_A;
                end
                HAVE_A: if (load_p) begin
                    op_b_q  <= sw;
                    state_q <= READY;
                end
                READY: if (shift_p) begin
                    step_q       <= 1'b1;
                    step_count_q <= SW'(1);
                    state_q      <= (WIDTH == 1) ? DONE : SHIFTING;
                end
                SHIFTING: if (shift_p) begin
                    step_q       <= 1'b1;
                    step_count_q <= step_count_q + 1'b1;
                    if (step_count_q == SW'(WIDTH - 1)) state_q <= DONE;
                end
                DONE: if (load_p) begin
                    op_a_q       <= sw;
                    step_count_q <= '0;
                    state_q      <= HAVE_A;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_a           = op_a_q;
    assign op_b           = op_b_q;
    assign step           = step_q;
    assign step_count     = step_count_q;
    assign operands_valid = (state_q == READY) || (state_q == SHIFTING) || (state_q == DONE);
    assign done           = (state_q == DONE);
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed checks of debounce timing, operand capture and shift sequencing
module tb_operand_loader;
    localparam int WIDTH = 8;
    localparam int DB    = 4;
    localparam int HOLD  = DB + 8;

    logic             clk = 1'b0;
    logic             reset, load_btn, shift_btn;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] op_a, op_b;
    logic             operands_valid, step, done;
    logic [3:0]       step_count;
    int               errs = 0;
    int               checks = 0;

    operand_loader #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .load_btn(load_btn), .shift_btn(shift_btn), .sw(sw),
        .op_a(op_a), .op_b(op_b), .operands_valid(operands_valid), .step(step),
        .step_count(step_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Press and release one button, counting step pulses and the step_count seen with them.
    task automatic press(input bit is_load, output int steps, output int sc);
        steps = 0;
        sc    = -1;
        @(negedge clk);
        if (is_load) load_btn = 1'b1; else shift_btn = 1'b1;
        for (int c = 0; c < 2 * HOLD; c++) begin
            if (c == HOLD) begin
                load_btn  = 1'b0;
                shift_btn = 1'b0;
            end
            @(negedge clk);
            if (step) begin
                steps++;
                sc = int'(step_count);
            end
        end
    endtask

    initial begin
        int st, sc;
        reset = 1'b1; load_btn = 1'b0; shift_btn = 1'b0; sw = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_op_a", 32'(op_a), 32'h0);
        check("rst_op_b", 32'(op_b), 32'h0);
        check("rst_valid", 32'(operands_valid), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        check("rst_count", 32'(step_count), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        press(1'b0, st, sc);
        check("idle_shift_steps", 32'(st), 32'h0);
        check("idle_shift_count", 32'(step_count), 32'h0);

        @(negedge clk);
        sw = 8'h5A;
        load_btn = 1'b1;
        repeat (DB + 3) @(negedge clk);
        check("lat_before", 32'(op_a), 32'h0);
        @(negedge clk);
        check("lat_at", 32'(op_a), 32'h5A);
        check("lat_valid", 32'(operands_valid), 32'h0);
        repeat (HOLD) @(negedge clk);
        load_btn = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("hold_one_load_b", 32'(op_b), 32'h0);

        sw = 8'hC3;
        load_btn = 1'b1;
        repeat (3) @(negedge clk);
        load_btn = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("glitch_op_a", 32'(op_a), 32'h5A);
        check("glitch_op_b", 32'(op_b), 32'h0);
        check("glitch_valid", 32'(operands_valid), 32'h0);

        sw = 8'h33;
        press(1'b1, st, sc);
        check("load_b_op_a", 32'(op_a), 32'h5A);
        check("load_b_op_b", 32'(op_b), 32'h33);
        check("load_b_valid", 32'(operands_valid), 32'h1);
        check("load_b_done", 32'(done), 32'h0);

        sw = 8'hFF;
        press(1'b1, st, sc);
        check("frozen_op_a", 32'(op_a), 32'h5A);
        check("frozen_op_b", 32'(op_b), 32'h33);
        check("frozen_count", 32'(step_count), 32'h0);
        check("frozen_valid", 32'(operands_valid), 32'h1);

        for (int i = 1; i <= WIDTH; i++) begin
            press(1'b0, st, sc);
            check($sformatf("shift%0d_steps", i), 32'(st), 32'h1);
            check($sformatf("shift%0d_count", i), 32'(sc), 32'(i));
            check($sformatf("shift%0d_done", i), 32'(done), (i == WIDTH) ? 32'h1 : 32'h0);
        end

        press(1'b0, st, sc);
        check("extra_steps", 32'(st), 32'h0);
        check("extra_count", 32'(step_count), 32'h8);
        check("extra_done", 32'(done), 32'h1);

        sw = 8'h0F;
        press(1'b1, st, sc);
        check("restart_op_a", 32'(op_a), 32'h0F);
        check("restart_op_b", 32'(op_b), 32'h33);
        check("restart_count", 32'(step_count), 32'h0);
        check("restart_done", 32'(done), 32'h0);
        check("restart_valid", 32'(operands_valid), 32'h0);

        sw = 8'h99;
        press(1'b1, st, sc);
        check("reload_op_b", 32'(op_b), 32'h99);
        for (int i = 1; i <= 4; i++) press(1'b0, st, sc);
        check("mid_count", 32'(step_count), 32'h4);
        check("mid_done", 32'(done), 32'h0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_count", 32'(step_count), 32'h0);
        check("midrst_op_a", 32'(op_a), 32'h0);
        check("midrst_op_b", 32'(op_b), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_valid", 32'(operands_valid), 32'h0);

        press(1'b0, st, sc);
        check("post_rst_steps", 32'(st), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
